// File: rtl/button_events.sv
// Button event generator: turns a debounced level into press/release,
// long-press and auto-repeat pulses, plus a wrapping press counter.
module button_events #(
    parameter int LONG_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stable,
    output logic       press,
    output logic       release_evt,
    output logic       long_press,
    output logic       repeat_evt,
    output logic       held,
    output logic [7:0] press_count
);

    localparam int MAXC = (LONG_CYCLES > REPEAT_CYCLES) ?
                          LONG_CYCLES : REPEAT_CYCLES;
    localparam int TW = $clog2(MAXC + 1);
    localparam logic [TW-1:0] LONG_T = TW'(LONG_CYCLES);
    localparam logic [TW-1:0] REP_T  = TW'(REPEAT_CYCLES);
    localparam logic [TW-1:0] ONE    = TW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEATING
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            press_count <= '0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
            held        <= 1'b0;
        end else begin
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (stable) begin
                        state       <= PRESSED;
                        tcnt        <= ONE;
                        press       <= 1'b1;
                        press_count <= press_count + 8'd1;
                        held        <= 1'b1;
                    end
                end
                PRESSED: begin
                    // release wins over a coincident threshold
                    if (!stable) begin
                        state       <= IDLE;
                        release_evt <= 1'b1;
                        held        <= 1'b0;
                    end else if (tcnt == LONG_T) begin
                        state      <= REPEATING;
                        tcnt       <= ONE;
                        long_press <= 1'b1;
                    end else begin
                        tcnt <= tcnt + ONE;
                    end
                end
                REPEATING: begin
                    if (!stable) begin
                        state       <= IDLE;
                        release_evt <= 1'b1;
                        held        <= 1'b0;
                    end else if (tcnt == REP_T) begin
                        tcnt       <= ONE;
                        repeat_evt <= 1'b1;
                    end else begin
                        tcnt <= tcnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule
